// File: rtl/hdb3_pkg.sv
// Shared definitions for the HDB3 transmit path: controller state encoding,
// default frame alignment byte and underrun counter sizing.
package hdb3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FAW     = 2'd1,
    ST_PAYLOAD = 2'd2
  } tx_state_e;

  localparam logic [7:0] FAW_DEFAULT    = 8'h1B;
  localparam int         UNDERRUN_CNT_W = 16;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hdb3_tx_serializer.sv
// 8-bit parallel-load shift register; the MSB is the serial output and zeros
// are shifted in behind the data.
module hdb3_tx_serializer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_bit
);

  logic [7:0] sr_q, sr_d;

  always_comb begin
    sr_d = {sr_q[6:0], 1'b0};
    if (i_load) begin
      sr_d = i_data;
    end
  end

  // NOTE: clocked state is written only with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_bit = sr_q[7];

endmodule

// File: rtl/hdb3_tx_ctrl.sv
// Frame controller: emits FAW then PAYLOAD_BYTES payload slots, MSB first,
// pulling bytes from upstream one cycle ahead of each slot and zero-filling gaps.
module hdb3_tx_ctrl
  import hdb3_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 31,
  parameter logic [7:0] FAW           = FAW_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic [7:0]                i_byte,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_clr_cnt,
  output logic                      o_data,
  output logic                      o_frame_start,
  output logic                      o_underrun,
  output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt,
  output logic [1:0]                o_state
);

  localparam int                SLOT_W     = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(PAYLOAD_BYTES);
  localparam logic [SLOT_W-1:0] FIRST_SLOT = SLOT_W'(1);

  tx_state_e                 state_q, state_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0]         slot_cnt_q, slot_cnt_d;
  logic                      ready_q, ready_d;
  logic                      frame_start_q, frame_start_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;
  logic                      sr_load;
  logic [7:0]                sr_din;
  logic                      slot_end;

  assign slot_end = (bit_cnt_q == 3'd7);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q + 3'd1;
    slot_cnt_d     = slot_cnt_q;
    sr_load        = 1'b0;
    sr_din         = 8'h00;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;

    // The handshake slot is the last bit of the slot preceding a payload slot.
    if (ready_q) begin
      sr_load = 1'b1;
      if (i_valid) begin
        sr_din = i_byte;
      end else begin
        underrun_d     = 1'b1;
        underrun_cnt_d = sat_inc(underrun_cnt_q);
      end
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = 3'd0;
        slot_cnt_d = '0;
        if (i_enable) begin
          state_d = ST_FAW;
          sr_load = 1'b1;
          sr_din  = FAW;
        end
      end
      ST_FAW: begin
        if (slot_end) begin
          state_d    = ST_PAYLOAD;
          slot_cnt_d = FIRST_SLOT;
        end
      end
      ST_PAYLOAD: begin
        if (slot_end) begin
          if (slot_cnt_q == LAST_SLOT) begin
            slot_cnt_d = '0;
            sr_load    = 1'b1;
            if (i_enable) begin
              state_d = ST_FAW;
              sr_din  = FAW;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        bit_cnt_d  = 3'd0;
        slot_cnt_d = '0;
      end
    endcase

    if (i_clr_cnt) begin
      underrun_cnt_d = '0;
    end

    ready_d = (bit_cnt_d == 3'd7) &&
              ((state_d == ST_FAW) ||
               ((state_d == ST_PAYLOAD) && (slot_cnt_d != LAST_SLOT)));
    frame_start_d = (state_d == ST_FAW) && (bit_cnt_d == 3'd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      slot_cnt_q     <= '0;
      ready_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      slot_cnt_q     <= slot_cnt_d;
      ready_q        <= ready_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  hdb3_tx_serializer u_serializer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (sr_load),
    .i_data (sr_din),
    .o_bit  (o_data)
  );

  assign o_ready        = ready_q;
  assign o_frame_start  = frame_start_q;
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = underrun_cnt_q;
  assign o_state        = state_q;

endmodule
